hazard_scoreboard: RTL

- Interlock controller that consumes the operand-fetch hazard request and the EX branch signal, and drives stall, flush and bubble controls back into the IF/OF and OF/EX pipeline registers.
- Keeps a per-register scoreboard of in-flight writes covering 16 registers, index 15 being the flag register.
- Writes are counted in at OF→EX issue and counted out at register write-back.
- Sits between operand_fetch, alu (branch) and register_write.

---
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Pipeline interlock with a per-register in-flight write
//                scoreboard, driving stall/flush/issue/bubble for IF/OF/EX.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int NUM_REGS     = 16,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int IDX_W        = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                of_valid,
    input  logic [IDX_W-1:0]    of_src1,
    input  logic                of_src1_en,
    input  logic [IDX_W-1:0]    of_src2,
    input  logic                of_src2_en,
    input  logic [IDX_W-1:0]    of_dest,
    input  logic                of_dest_en,
    input  logic                br_taken,
    input  logic                rw_write_en,
    input  logic [IDX_W-1:0]    rw_addr,
    output logic                stall,
    output logic                flush,
    output logic                issue,
    output logic                bubble,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                sb_error
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
    localparam logic [FC_W-1:0]  C_FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [FC_W-1:0]     flush_cnt_q;
    logic [FC_W-1:0]     flush_cnt_d;
    logic                sb_error_q;
    logic                sb_error_d;

    logic                w_haz;
    logic                w_flush;
    logic                w_issue;
    logic                w_stall;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;

    // Control outputs are forced to their idle values while reset is held,
    // independent of whatever the pipeline is presenting on the inputs.
    always_comb begin
        w_haz   = (of_src1_en && (cnt_q[of_src1] != '0))
               || (of_src2_en && (cnt_q[of_src2] != '0))
               || (of_dest_en && (cnt_q[of_dest] == C_CNT_MAX));
        w_flush = rst_n && (br_taken || (flush_cnt_q != '0));
        w_issue = rst_n && of_valid && !w_flush && !w_haz;
        w_stall = rst_n && of_valid && !w_flush && w_haz;
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_inc[r] = w_issue && of_dest_en && (of_dest == IDX_W'(r));
            w_dec[r] = rw_write_en && (rw_addr == IDX_W'(r));
        end
    end

    // A retire against an empty counter is a bookkeeping fault; the counter
    // holds at zero and the sticky error flag records it.
    always_comb begin
        sb_error_d = sb_error_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (w_inc[r] && !w_dec[r]) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (!w_inc[r] && w_dec[r]) begin
                if (cnt_q[r] == '0) begin
                    sb_error_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (br_taken) begin
            flush_cnt_d = C_FLUSH_LOAD;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            flush_cnt_q <= '0;
            sb_error_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
            sb_error_q  <= sb_error_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign stall    = w_stall;
    assign flush    = w_flush;
    assign issue    = w_issue;
    assign bubble   = !w_issue;
    assign sb_error = sb_error_q;

endmodule

`default_nettype wire
